// File: rtl/div_unit_pkg.sv
// Shared encodings for the radix-2 restoring divider: FSM state codes,
// the EX-stage alucontrol codes that qualify the HI/LO write, and the divide-by-zero quotient.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic [7:0]  EXE_DIV_OP    = 8'b0001_1010;
    localparam logic [7:0]  EXE_DIVU_OP   = 8'b0001_1011;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit_sign_fix.sv
// Conditional two's-complement negate: used both to take operand magnitudes
// and to restore the sign of quotient/remainder.
module div_unit_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    // Negate when requested, pass through otherwise.
    always_comb begin
        if (neg) begin
            res = ~val + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: remainder to HI, quotient to LO,
// one result_ready_o strobe per completed divide.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             result_ready_o,
    output logic             stall_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r, quot_r, divisor_r, dividend_r;
    logic             neg_quot_r, neg_rem_r;
    logic [WIDTH-1:0] opa_mag_s, opb_mag_s, quot_fix_s, rem_fix_s;
    logic [WIDTH:0]   trial_s;
    logic             accept_s, last_step_s, opb_zero_s;

    div_unit_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .val (opa_i),
        .neg (signed_i & opa_i[WIDTH-1]),
        .res (opa_mag_s)
    );

    div_unit_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .val (opb_i),
        .neg (signed_i & opb_i[WIDTH-1]),
        .res (opb_mag_s)
    );

    div_unit_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .val (quot_r),
        .neg (neg_quot_r),
        .res (quot_fix_s)
    );

    div_unit_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .val (rem_r),
        .neg (neg_rem_r),
        .res (rem_fix_s)
    );

    assign stall_o = start_i & ~result_ready_o;

    // Acceptance, last-step detect and the trial subtraction of the shifted partial remainder.
    always_comb begin
        accept_s    = (state_r == DIV_IDLE) & start_i & ~annul_i;
        last_step_s = (cnt_r == LAST_CNT);
        opb_zero_s  = (opb_i == {WIDTH{1'b0}});
        trial_s     = {rem_r, quot_r[WIDTH-1]} - {1'b0, divisor_r};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; annul only cancels work that has not yet reached END.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (accept_s) begin
                    if (opb_zero_s) begin
                        state_nxt_s = DIV_BYZERO;
                    end else begin
                        state_nxt_s = DIV_ON;
                    end
                end else begin
                    state_nxt_s = DIV_IDLE;
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_nxt_s = DIV_IDLE;
                end else begin
                    state_nxt_s = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_nxt_s = DIV_IDLE;
                end else if (last_step_s) begin
                    state_nxt_s = DIV_END;
                end else begin
                    state_nxt_s = DIV_ON;
                end
            end
            DIV_END: begin
                state_nxt_s = DIV_IDLE;
            end
            default: begin
                state_nxt_s = DIV_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one restoring step per ON cycle, registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r          <= {CNT_W{1'b0}};
            rem_r          <= {WIDTH{1'b0}};
            quot_r         <= {WIDTH{1'b0}};
            divisor_r      <= {WIDTH{1'b0}};
            dividend_r     <= {WIDTH{1'b0}};
            neg_quot_r     <= 1'b0;
            neg_rem_r      <= 1'b0;
            hi_o           <= {WIDTH{1'b0}};
            lo_o           <= {WIDTH{1'b0}};
            result_ready_o <= 1'b0;
        end else begin
            result_ready_o <= 1'b0;
            case (state_r)
                DIV_IDLE: begin
                    if (accept_s) begin
                        dividend_r <= opa_i;
                        divisor_r  <= opb_mag_s;
                        rem_r      <= {WIDTH{1'b0}};
                        quot_r     <= opa_mag_s;
                        cnt_r      <= {CNT_W{1'b0}};
                        neg_quot_r <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                        neg_rem_r  <= signed_i & opa_i[WIDTH-1];
                    end
                end
                DIV_BYZERO: begin
                    // Raw dividend and all-ones quotient, no sign fixup.
                    rem_r      <= dividend_r;
                    quot_r     <= {WIDTH{1'b1}};
                    neg_quot_r <= 1'b0;
                    neg_rem_r  <= 1'b0;
                end
                DIV_ON: begin
                    if (!trial_s[WIDTH]) begin
                        rem_r  <= trial_s[WIDTH-1:0];
                        quot_r <= {quot_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r  <= {rem_r[WIDTH-2:0], quot_r[WIDTH-1]};
                        quot_r <= {quot_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                DIV_END: begin
                    hi_o           <= rem_fix_s;
                    lo_o           <= quot_fix_s;
                    result_ready_o <= 1'b1;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule
